// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command sequencer: command record, FSM states, bus widths.
package apb_cmd_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, XFER, CAPT, RESP} state_t;
endpackage

// File: rtl/apb_cmd_sequencer_if.sv
// Host-side command/response handshake bundle for the APB command sequencer.
interface apb_cmd_sequencer_if;
  import apb_cmd_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_rw;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_err, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Command FIFO; head is presented combinationally, storage is not reset.
module apb_cmd_fifo
  import apb_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  cmd_t             i_din,
  input  logic             i_pop,
  output cmd_t             o_dout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end
endmodule

// File: rtl/apb_cmd_sequencer.sv
// Queues host commands and issues them one at a time to the APB bridge,
// returning read data / slave error / timeout per command.
module apb_cmd_sequencer
  import apb_cmd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int TW     = $clog2(TIMEOUT)
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_cmd_sequencer_if.slave  hif,
  output logic                transfer,
  output logic                READ_WRITE,
  output logic [ADDR_W-1:0]   apb_write_paddr,
  output logic [DATA_W-1:0]   apb_write_data,
  output logic [ADDR_W-1:0]   apb_read_paddr,
  input  logic [DATA_W-1:0]   apb_read_data_out,
  input  logic                PSLVERR,
  input  logic                xfer_done,
  output logic [CNT_W-1:0]    fifo_level,
  output logic                busy
);
  state_t            r_state,  w_state_nxt;
  logic [TW-1:0]     r_timer,  w_timer_nxt;
  logic              r_tr,     w_tr_nxt;
  logic              r_rw,     w_rw_nxt;
  logic [ADDR_W-1:0] r_wpa,    w_wpa_nxt;
  logic [DATA_W-1:0] r_wd,     w_wd_nxt;
  logic [ADDR_W-1:0] r_rpa,    w_rpa_nxt;
  logic              r_rv,     w_rv_nxt;
  logic              r_rrw,    w_rrw_nxt;
  logic [DATA_W-1:0] r_rd,     w_rd_nxt;
  logic              r_err,    w_err_nxt;
  logic              r_to,     w_to_nxt;

  logic              w_push;
  logic              w_pop;
  cmd_t              w_din;
  cmd_t              w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;

  // cmd_ready is held low during reset even though the count already reads 0
  assign hif.cmd_ready = !PRESET && !w_full;
  assign w_push        = hif.cmd_valid && hif.cmd_ready;
  assign w_din         = '{rw: hif.cmd_rw, addr: hif.cmd_addr, wdata: hif.cmd_wdata};

  apb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (PCLK),
    .rst     (PRESET),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_tr_nxt    = r_tr;
    w_rw_nxt    = r_rw;
    w_wpa_nxt   = r_wpa;
    w_wd_nxt    = r_wd;
    w_rpa_nxt   = r_rpa;
    w_rv_nxt    = r_rv;
    w_rrw_nxt   = r_rrw;
    w_rd_nxt    = r_rd;
    w_err_nxt   = r_err;
    w_to_nxt    = r_to;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_tr_nxt    = 1'b1;
          w_rw_nxt    = w_head.rw;
          w_timer_nxt = '0;
          w_wpa_nxt   = w_head.rw ? '0 : w_head.addr;
          w_wd_nxt    = w_head.rw ? '0 : w_head.wdata;
          w_rpa_nxt   = w_head.rw ? w_head.addr : '0;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        // Completion takes priority over a timeout landing in the same cycle
        if (xfer_done) begin
          w_tr_nxt    = 1'b0;
          w_state_nxt = CAPT;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_tr_nxt    = 1'b0;
          w_rv_nxt    = 1'b1;
          w_rrw_nxt   = r_rw;
          w_rd_nxt    = '0;
          w_err_nxt   = 1'b1;
          w_to_nxt    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      CAPT: begin
        // Bridge read data is valid only the cycle after the completing edge
        w_rv_nxt    = 1'b1;
        w_rrw_nxt   = r_rw;
        w_rd_nxt    = r_rw ? apb_read_data_out : '0;
        w_err_nxt   = PSLVERR;
        w_to_nxt    = 1'b0;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (hif.rsp_ready) begin
          w_rv_nxt    = 1'b0;
          w_err_nxt   = 1'b0;
          w_to_nxt    = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_tr    <= 1'b0;
      r_rw    <= 1'b0;
      r_wpa   <= '0;
      r_wd    <= '0;
      r_rpa   <= '0;
      r_rv    <= 1'b0;
      r_rrw   <= 1'b0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_tr    <= w_tr_nxt;
      r_rw    <= w_rw_nxt;
      r_wpa   <= w_wpa_nxt;
      r_wd    <= w_wd_nxt;
      r_rpa   <= w_rpa_nxt;
      r_rv    <= w_rv_nxt;
      r_rrw   <= w_rrw_nxt;
      r_rd    <= w_rd_nxt;
      r_err   <= w_err_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign transfer        = r_tr;
  assign READ_WRITE      = r_rw;
  assign apb_write_paddr = r_wpa;
  assign apb_write_data  = r_wd;
  assign apb_read_paddr  = r_rpa;
  assign hif.rsp_valid   = r_rv;
  assign hif.rsp_rw      = r_rrw;
  assign hif.rsp_rdata   = r_rd;
  assign hif.rsp_err     = r_err;
  assign hif.rsp_timeout = r_to;
  assign fifo_level      = w_count;
  assign busy            = (r_state != IDLE) || !w_empty;
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer with a queue-based reference model
// compared against every output on each falling clock edge.
module tb_apb_cmd_sequencer;
  import apb_cmd_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       transfer, rw_o, busy;
  logic [8:0] wpa, rpa;
  logic [7:0] wd;
  logic [7:0] rdata_in;
  logic       pslverr, xdone;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_cmd_sequencer_if hif();

  apb_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .PCLK              (clk),
    .PRESET            (rst),
    .hif               (hif),
    .transfer          (transfer),
    .READ_WRITE        (rw_o),
    .apb_write_paddr   (wpa),
    .apb_write_data    (wd),
    .apb_read_paddr    (rpa),
    .apb_read_data_out (rdata_in),
    .PSLVERR           (pslverr),
    .xfer_done         (xdone),
    .fifo_level        (level),
    .busy              (busy)
  );

  // Reference model: a command queue plus the in-flight command's progress.
  cmd_t mq[$];
  cmd_t cur, inc;
  int   ph;   // 0 waiting for work, 1 on the bus, 2 capturing result, 3 holding response
  int   age;  // cycles the in-flight command has spent on the bus
  bit   mpush;
  bit   e_tr, e_rw, e_rv, e_rrw, e_err, e_to;
  bit [8:0] e_wpa, e_rpa;
  bit [7:0] e_wd, e_rd;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        ph = 0; age = 0;
        e_tr = 0; e_rw = 0; e_rv = 0; e_rrw = 0; e_err = 0; e_to = 0;
        e_wpa = 0; e_rpa = 0; e_wd = 0; e_rd = 0;
      end else begin
        mpush = hif.cmd_valid && (mq.size() < DEPTH);
        inc   = {hif.cmd_rw, hif.cmd_addr, hif.cmd_wdata};
        case (ph)
          0: if (mq.size() > 0) begin
               cur   = mq.pop_front();
               e_tr  = 1;
               e_rw  = cur.rw;
               e_wpa = cur.rw ? 9'h0 : cur.addr;
               e_wd  = cur.rw ? 8'h0 : cur.wdata;
               e_rpa = cur.rw ? cur.addr : 9'h0;
               age   = 1;
               ph    = 1;
             end
          1: if (xdone) begin
               e_tr = 0; ph = 2;
             end else if (age == TIMEOUT) begin
               e_tr = 0; e_rv = 1; e_rrw = cur.rw; e_rd = 0; e_err = 1; e_to = 1; ph = 3;
             end else begin
               age++;
             end
          2: begin
               e_rv = 1; e_rrw = cur.rw; e_rd = cur.rw ? rdata_in : 8'h0;
               e_err = pslverr; e_to = 0; ph = 3;
             end
          default: if (hif.rsp_ready) begin
               e_rv = 0; e_err = 0; e_to = 0; ph = 0;
             end
        endcase
        if (mpush) mq.push_back(inc);
      end
    end
  end

  logic [44:0] act_v, exp_v;
  initial begin
    forever begin
      @(negedge clk);
      exp_v = {e_tr, e_rw, e_wpa, e_wd, e_rpa, e_rv, e_rrw, e_rd, e_err, e_to,
               3'(mq.size()), (!rst && mq.size() < DEPTH), (!rst && (ph != 0 || mq.size() != 0))};
      act_v = {transfer, rw_o, wpa, wd, rpa, hif.rsp_valid, hif.rsp_rw, hif.rsp_rdata,
               hif.rsp_err, hif.rsp_timeout, level, hif.cmd_ready, busy};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_cycle t=%0t act=%h exp=%h", $time, act_v, exp_v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    return (which == 0) ? transfer : hif.rsp_valid;
  endfunction

  task automatic wait_until(input int which, input string name);
    int n = 0;
    while (sig(which) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (sig(which) !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s wait expired act=0 exp=1", name);
    end
  endtask

  task automatic push(input logic rw, input logic [8:0] addr, input logic [7:0] wdat);
    hif.cmd_valid = 1'b1;
    hif.cmd_rw    = rw;
    hif.cmd_addr  = addr;
    hif.cmd_wdata = wdat;
    tick();
    hif.cmd_valid = 1'b0;
  endtask

  task automatic pulse_done();
    xdone = 1'b1;
    tick();
    xdone = 1'b0;
  endtask

  task automatic accept();
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
  endtask

  int acc;
  int n;

  initial begin
    hif.cmd_valid = 0; hif.cmd_rw = 0; hif.cmd_addr = 0; hif.cmd_wdata = 0; hif.rsp_ready = 0;
    rdata_in = 0; pslverr = 0; xdone = 0;

    // Reset
    #1 rst = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(hif.cmd_ready), 0);
    chk("rst_transfer", 32'(transfer), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(hif.cmd_ready), 1);
    chk("post_rst_level", 32'(level), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Write
    push(1'b0, 9'h012, 8'hA5);
    wait_until(0, "wr_transfer");
    chk("wr_paddr", 32'(wpa), 32'h012);
    chk("wr_data", 32'(wd), 32'hA5);
    chk("wr_rw", 32'(rw_o), 0);
    chk("wr_rpaddr", 32'(rpa), 0);
    tick(); tick();
    pulse_done();
    chk("wr_tr_fall", 32'(transfer), 0);
    wait_until(1, "wr_rsp");
    chk("wr_rsp_rw", 32'(hif.rsp_rw), 0);
    chk("wr_rsp_rdata", 32'(hif.rsp_rdata), 0);
    chk("wr_rsp_err", 32'(hif.rsp_err), 0);
    accept();
    chk("wr_rsp_clear", 32'(hif.rsp_valid), 0);

    // Read from slave2 with slave error
    push(1'b1, 9'h105, 8'h00);
    wait_until(0, "rd_transfer");
    chk("rd_rpaddr", 32'(rpa), 32'h105);
    chk("rd_rw", 32'(rw_o), 1);
    chk("rd_wpaddr", 32'(wpa), 0);
    tick();
    pulse_done();
    rdata_in = 8'h3C; pslverr = 1'b1;
    tick();
    rdata_in = 8'h00; pslverr = 1'b0;
    wait_until(1, "rd_rsp");
    chk("rd_rsp_rdata", 32'(hif.rsp_rdata), 32'h3C);
    chk("rd_rsp_err", 32'(hif.rsp_err), 1);
    chk("rd_rsp_timeout", 32'(hif.rsp_timeout), 0);
    chk("rd_rsp_rw", 32'(hif.rsp_rw), 1);
    accept();

    // Backpressure / full
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      hif.cmd_valid = 1'b1; hif.cmd_rw = 1'b0;
      hif.cmd_addr = 9'h020 + 9'(i); hif.cmd_wdata = 8'h50 + 8'(i);
      if (hif.cmd_ready) acc++;
      tick();
    end
    hif.cmd_valid = 1'b0;
    chk("full_accepted", 32'(acc), 5);
    chk("full_cmd_ready", 32'(hif.cmd_ready), 0);
    chk("full_level", 32'(level), 4);
    for (int k = 0; k < 5; k++) begin
      wait_until(0, "drain_transfer");
      chk("drain_order", 32'(wpa), 32'h020 + 32'(k));
      chk("drain_level", 32'(level), 32'(4 - k));
      pulse_done();
      wait_until(1, "drain_rsp");
      chk("drain_rsp_rw", 32'(hif.rsp_rw), 0);
      accept();
    end
    chk("drain_level_end", 32'(level), 0);
    chk("drain_busy_end", 32'(busy), 0);

    // Timeout
    push(1'b1, 9'h0AB, 8'h00);
    wait_until(0, "to_transfer");
    n = 0;
    while (transfer && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", 32'(n), 16);
    chk("to_rsp_valid", 32'(hif.rsp_valid), 1);
    chk("to_rsp_timeout", 32'(hif.rsp_timeout), 1);
    chk("to_rsp_err", 32'(hif.rsp_err), 1);
    chk("to_rsp_rdata", 32'(hif.rsp_rdata), 0);
    pulse_done();
    chk("to_late_done_valid", 32'(hif.rsp_valid), 1);
    chk("to_late_done_timeout", 32'(hif.rsp_timeout), 1);
    chk("to_late_done_tr", 32'(transfer), 0);
    accept();
    chk("to_clear_timeout", 32'(hif.rsp_timeout), 0);

    // Reset mid-transfer with commands queued
    hif.cmd_valid = 1'b1; hif.cmd_rw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hif.cmd_addr = 9'h030 + 9'(i); hif.cmd_wdata = 8'h70 + 8'(i);
      tick();
    end
    hif.cmd_valid = 1'b0;
    wait_until(0, "mid_transfer");
    chk("mid_level", 32'(level), 2);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_transfer", 32'(transfer), 0);
    chk("mid_rst_rsp_valid", 32'(hif.rsp_valid), 0);
    chk("mid_rst_cmd_ready", 32'(hif.cmd_ready), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_post_level", 32'(level), 0);
    chk("mid_post_busy", 32'(busy), 0);
    chk("mid_post_cmd_ready", 32'(hif.cmd_ready), 1);
    chk("mid_post_rsp_valid", 32'(hif.rsp_valid), 0);
    chk("mid_post_transfer", 32'(transfer), 0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_cmd_sequencer.md
Name: apb_cmd_sequencer

Overview:
- Upstream command stage for APB_Protocol: accepts host read/write commands on a valid/ready interface and queues them in a small FIFO.
- Issues commands one at a time on APB_Protocol's transfer/READ_WRITE/address/data inputs, then returns per-command responses (read data, slave error, timeout).
- Completion is the xfer_done strobe, PENABLE&&PREADY exported from APB_Protocol.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT, 16: cycles in XFER without xfer_done before the command is aborted; at least 2.

Ports:
- PCLK, in, 1: clock, rising edge.
- PRESET, in, 1: asynchronous, active-high reset.
- cmd_valid, in, 1: host command valid.
- cmd_ready, out, 1: FIFO can accept a command.
- cmd_rw, in, 1: 1 = read, 0 = write (READ_WRITE encoding).
- cmd_addr, in, 9: bit 8 selects slave2, bits 7:0 are the slave offset.
- cmd_wdata, in, 8: write data.
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: host accepts response.
- rsp_rw, out, 1: rw bit of the completed command.
- rsp_rdata, out, 8: read data; 0 for writes and timeouts.
- rsp_err, out, 1: PSLVERR seen, or timeout.
- rsp_timeout, out, 1: command aborted by timeout.
- transfer, out, 1: to APB_Protocol transfer.
- READ_WRITE, out, 1: to APB_Protocol READ_WRITE.
- apb_write_paddr, out, 9: write address.
- apb_write_data, out, 8: write data.
- apb_read_paddr, out, 9: read address.
- apb_read_data_out, in, 8: read data from APB_Protocol.
- PSLVERR, in, 1: slave error from APB_Protocol.
- xfer_done, in, 1: one-cycle completion pulse (PENABLE&&PREADY).
- fifo_level, out, $clog2(DEPTH+1): queued entries, excluding the in-flight command.
- busy, out, 1: FSM not IDLE, or FIFO non-empty.

Behaviour:
- Reset: asynchronous, active-high. While PRESET is high, all outputs are 0, including cmd_ready; the FIFO is flushed and the FSM goes to IDLE. cmd_ready rises in the first cycle after release.
- All outputs are registered except cmd_ready and busy.
- FIFO:
  - cmd_ready = (count < DEPTH), computed from registered count.
  - A command is pushed when cmd_valid && cmd_ready.
  - When full, cmd_ready stays low even in a cycle that pops.
  - Simultaneous push and pop with count < DEPTH leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, XFER, CAPT, RESP.
- IDLE:
  - If the FIFO is non-empty: pop the head into the issue registers, assert transfer and drive READ_WRITE = rw on the next edge, clear the timer, go to XFER.
  - For a write: apb_write_paddr = addr, apb_write_data = wdata, apb_read_paddr = 0.
  - For a read: apb_read_paddr = addr, apb_write_paddr = 0, apb_write_data = 0.
- XFER:
  - transfer and the address/data outputs are held stable; the timer increments each cycle.
  - If xfer_done = 1: deassert transfer on the next edge, go to CAPT.
  - Else if timer == TIMEOUT-1: deassert transfer, set rsp_timeout = 1, rsp_err = 1, rsp_rdata = 0, go to RESP.
  - xfer_done and timeout in the same cycle: xfer_done wins.
- CAPT (one cycle):
  - The bridge registers read data on the completing edge, so this state samples apb_read_data_out (reads only; writes give 0) and PSLVERR into the response registers, then goes to RESP.
- RESP:
  - rsp_valid = 1 with all rsp_* fields stable until rsp_ready. On acceptance, clear rsp_valid, rsp_err and rsp_timeout, and go to IDLE.
  - The FIFO keeps accepting commands during RESP.
- Spacing: transfer is low for at least 2 cycles between commands (RESP + IDLE), so the bridge always sees a transfer edge.
- xfer_done outside XFER is ignored.
- Reset in any state aborts the in-flight command with no response, and transfer drops immediately.
- Maximum accepted-but-uncompleted commands: DEPTH + 1 (FIFO plus issue registers).

Decomposition:
- Package apb_cmd_pkg:
  - ADDR_W = 9, DATA_W = 8.
  - cmd_t packed struct {rw, addr[8:0], wdata[7:0]}.
  - state_t enum {IDLE, XFER, CAPT, RESP}.
- Sub-module apb_cmd_fifo (parameter DEPTH, element type cmd_t): push, pop, count, full, empty.
- FSM, timer and response registers live in apb_cmd_sequencer.

Test Plan:
- Reset: assert PRESET mid-cycle -> all outputs 0 immediately. After release -> cmd_ready = 1, fifo_level = 0, busy = 0.
- Write: push rw=0, addr 0x012, wdata 0xA5; pulse xfer_done 3 cycles after transfer rises -> apb_write_paddr = 0x012, apb_write_data = 0xA5, READ_WRITE = 0. Then rsp_valid with rsp_rw = 0, rsp_rdata = 0x00, rsp_err = 0. transfer falls the cycle after xfer_done.
- Read from slave2: push rw=1, addr 0x105; apb_read_data_out = 0x3C and PSLVERR = 1 in the cycle after xfer_done -> apb_read_paddr = 0x105, READ_WRITE = 1, rsp_rdata = 0x3C, rsp_err = 1, rsp_timeout = 0.
- Backpressure/full: rsp_ready = 0, no xfer_done, push 6 commands back-to-back (DEPTH=4) -> 5 accepted, cmd_ready = 0, fifo_level = 4. Then complete and drain all -> responses in push order, fifo_level decrements to 0.
- Timeout: push a read, never pulse xfer_done -> after 16 XFER cycles transfer = 0, rsp_valid = 1, rsp_timeout = 1, rsp_err = 1, rsp_rdata = 0. A late xfer_done in RESP is ignored.
- Reset mid-XFER with 2 commands queued -> transfer = 0 asynchronously, no rsp_valid, fifo_level = 0 after release.
